// File: rtl/sd_test_pkg.sv
// sd_test_pkg: shared types and pattern helpers for the SD SPI self-test sequencer.
package sd_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_START,
      ST_WR_WAIT,
      ST_RD_START,
      ST_RD_WAIT,
      ST_CHECK,
      ST_DONE
   } seq_state_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Counter pattern: sector index in bits [23:8], word index OR-ed into the low bits.
   function automatic logic [31:0] pattern_word(input logic [15:0] sec, input logic [15:0] word);
      return {8'h00, sec, 8'h00} | {16'h0000, word};
   endfunction

   // One step of a left-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[31] ? ((s << 1) ^ LFSR_POLY) : (s << 1);
   endfunction

endpackage

// File: rtl/sd_test_pattern_gen.sv
// sd_test_pattern_gen: per-sector test data source; init loads the sector, step advances one word.
// SD_TEST_LFSR_EN selects an LFSR sequence seeded with START_ADDR+sector instead of the counter pattern.
module sd_test_pattern_gen
   import sd_test_pkg::*;
#(
   parameter int unsigned DATA_W     = 16
`ifdef SD_TEST_LFSR_EN
   ,
   parameter logic [31:0] START_ADDR = 32'd2000
`endif
) (
   input  logic              clk_sd,
   input  logic              reset,
   input  logic              init_i,
   input  logic              step_i,
   input  logic [15:0]       sec_i,
   output logic [DATA_W-1:0] data_o
);

`ifdef SD_TEST_LFSR_EN
   logic [31:0] lfsr_q;

   // Seed per sector, advance once per consumed word.
   always_ff @(posedge clk_sd) begin
      if (reset) begin
         lfsr_q <= '0;
      end else if (init_i) begin
         lfsr_q <= START_ADDR + {16'h0000, sec_i};
      end else if (step_i) begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   assign data_o = lfsr_q[DATA_W-1:0];
`else
   logic [15:0] sec_q;
   logic [15:0] idx_q;

   // Latch the sector on init, count words on step.
   always_ff @(posedge clk_sd) begin
      if (reset) begin
         sec_q <= '0;
         idx_q <= '0;
      end else if (init_i) begin
         sec_q <= sec_i;
         idx_q <= '0;
      end else if (step_i) begin
         idx_q <= idx_q + 16'd1;
      end
   end

   assign data_o = DATA_W'(pattern_word(sec_q, idx_q));
`endif

endmodule

// File: rtl/sd_spi_test_seq.sv
// sd_spi_test_seq: writes SEC_CNT sectors with a test pattern, reads them back and checks every word.
// Optional build macro SD_TEST_LFSR_EN switches the data pattern to a per-sector LFSR.
module sd_spi_test_seq
   import sd_test_pkg::*;
#(
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned WORDS_PER_SEC = 256,
   parameter int unsigned SEC_CNT       = 4,
   parameter logic [31:0] START_ADDR    = 32'd2000
) (
   input  logic              clk_sd,
   input  logic              reset,
   input  logic              sd_init_done,
   input  logic              restart,
   input  logic              wr_busy,
   input  logic              wr_req,
   output logic              wr_start_en,
   output logic [31:0]       wr_sec_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              rd_busy,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_start_en,
   output logic [31:0]       rd_sec_addr,
   output logic              test_done,
   output logic              error_flag,
   output logic [15:0]       err_cnt,
   output logic [31:0]       fail_sec
);

   // One spare count above WORDS_PER_SEC so an over-long read stays distinguishable.
   localparam int unsigned     CNT_W    = $clog2(WORDS_PER_SEC + 2);
   localparam logic [CNT_W-1:0] WPS_C   = CNT_W'(WORDS_PER_SEC);
   localparam logic [15:0]      LAST_SEC = 16'(SEC_CNT - 1);

   seq_state_e        state_q;
   logic              init_prev_q;
   logic              wr_busy_q;
   logic              rd_busy_q;
   logic [15:0]       sec_idx_q;
   logic [CNT_W-1:0]  w_q;
   logic [CNT_W-1:0]  r_q;
   logic              wr_start_q;
   logic              rd_start_q;
   logic [31:0]       wr_addr_q;
   logic [31:0]       rd_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              test_done_q;
   logic              error_q;
   logic [15:0]       err_cnt_q;
   logic [31:0]       fail_sec_q;
   logic              fail_vld_q;

   logic              trigger;
   logic              gen_init;
   logic              wr_step;
   logic              rd_step;
   logic [DATA_W-1:0] wr_pat;
   logic [DATA_W-1:0] chk_pat;

   assign trigger  = ((sd_init_done && !init_prev_q) || restart) &&
                     (state_q == ST_IDLE || state_q == ST_DONE);
   assign gen_init = (state_q == ST_WR_START);
   assign wr_step  = (state_q == ST_WR_WAIT) && wr_req && (w_q < WPS_C);
   assign rd_step  = (state_q == ST_RD_WAIT) && rd_en && (r_q < WPS_C);

   sd_test_pattern_gen #(
      .DATA_W     (DATA_W)
`ifdef SD_TEST_LFSR_EN
      ,
      .START_ADDR (START_ADDR)
`endif
   ) u_wr_gen (
      .clk_sd (clk_sd),
      .reset  (reset),
      .init_i (gen_init),
      .step_i (wr_step),
      .sec_i  (sec_idx_q),
      .data_o (wr_pat)
   );

   sd_test_pattern_gen #(
      .DATA_W     (DATA_W)
`ifdef SD_TEST_LFSR_EN
      ,
      .START_ADDR (START_ADDR)
`endif
   ) u_chk_gen (
      .clk_sd (clk_sd),
      .reset  (reset),
      .init_i (gen_init),
      .step_i (rd_step),
      .sec_i  (sec_idx_q),
      .data_o (chk_pat)
   );

   // Sequencer FSM with registered start pulses, write data and status.
   always_ff @(posedge clk_sd) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         init_prev_q <= 1'b0;
         wr_busy_q   <= 1'b0;
         rd_busy_q   <= 1'b0;
         sec_idx_q   <= '0;
         w_q         <= '0;
         r_q         <= '0;
         wr_start_q  <= 1'b0;
         rd_start_q  <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         wr_data_q   <= '0;
         test_done_q <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         fail_sec_q  <= '0;
         fail_vld_q  <= 1'b0;
      end else begin
         init_prev_q <= sd_init_done;
         wr_busy_q   <= wr_busy;
         rd_busy_q   <= rd_busy;
         wr_start_q  <= 1'b0;
         rd_start_q  <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (trigger) begin
                  test_done_q <= 1'b0;
                  error_q     <= 1'b0;
                  err_cnt_q   <= '0;
                  fail_sec_q  <= '0;
                  fail_vld_q  <= 1'b0;
                  sec_idx_q   <= '0;
                  w_q         <= '0;
                  r_q         <= '0;
                  wr_start_q  <= 1'b1;
                  wr_addr_q   <= START_ADDR;
                  state_q     <= ST_WR_START;
               end
            end
            ST_WR_START: begin
               state_q <= ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
               if (wr_req) begin
                  if (w_q < WPS_C) begin
                     wr_data_q <= wr_pat;
                     w_q       <= w_q + CNT_W'(1);
                  end else begin
                     wr_data_q <= '0;
                     error_q   <= 1'b1;
                  end
               end
               if (wr_busy_q && !wr_busy) begin
                  rd_start_q <= 1'b1;
                  rd_addr_q  <= wr_addr_q;
                  state_q    <= ST_RD_START;
               end
            end
            ST_RD_START: begin
               state_q <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (rd_en) begin
                  if ((r_q < WPS_C) && (rd_data != chk_pat)) begin
                     error_q <= 1'b1;
                     if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                     end
                     if (!fail_vld_q) begin
                        fail_vld_q <= 1'b1;
                        fail_sec_q <= rd_addr_q;
                     end
                  end
                  if (r_q != '1) begin
                     r_q <= r_q + CNT_W'(1);
                  end
               end
               if (rd_busy_q && !rd_busy) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (r_q != WPS_C) begin
                  error_q <= 1'b1;
                  if (!fail_vld_q) begin
                     fail_vld_q <= 1'b1;
                     fail_sec_q <= rd_addr_q;
                  end
               end
               if (sec_idx_q == LAST_SEC) begin
                  test_done_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  sec_idx_q  <= sec_idx_q + 16'd1;
                  w_q        <= '0;
                  r_q        <= '0;
                  wr_start_q <= 1'b1;
                  wr_addr_q  <= START_ADDR + {16'h0000, 16'(sec_idx_q + 16'd1)};
                  state_q    <= ST_WR_START;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_start_en = wr_start_q;
   assign wr_sec_addr = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign rd_start_en = rd_start_q;
   assign rd_sec_addr = rd_addr_q;
   assign test_done   = test_done_q;
   assign error_flag  = error_q;
   assign err_cnt     = err_cnt_q;
   assign fail_sec    = fail_sec_q;

endmodule

// File: tb/tb_sd_spi_test_seq.sv
// tb_sd_spi_test_seq: randomized loopback controller model with a sector-level expected-result model.
module tb_sd_spi_test_seq;

   localparam int unsigned DW   = 16;
   localparam int unsigned WPS  = 256;
   localparam int unsigned NSEC = 2;
   localparam logic [31:0] SA   = 32'd2000;

   logic          clk_sd = 1'b0;
   logic          reset = 1'b1;
   logic          sd_init_done = 1'b0;
   logic          restart = 1'b0;
   logic          wr_busy = 1'b0;
   logic          wr_req = 1'b0;
   logic          rd_busy = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data = '0;
   logic          wr_start_en, rd_start_en, test_done, error_flag;
   logic [31:0]   wr_sec_addr, rd_sec_addr, fail_sec;
   logic [DW-1:0] wr_data;
   logic [15:0]   err_cnt;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mem [NSEC][WPS];
   bit            corrupt [NSEC][WPS];
   int            nread [NSEC];

   always #5 clk_sd = ~clk_sd;

   sd_spi_test_seq #(
      .DATA_W        (DW),
      .WORDS_PER_SEC (WPS),
      .SEC_CNT       (NSEC),
      .START_ADDR    (SA)
   ) dut (
      .clk_sd       (clk_sd),
      .reset        (reset),
      .sd_init_done (sd_init_done),
      .restart      (restart),
      .wr_busy      (wr_busy),
      .wr_req       (wr_req),
      .wr_start_en  (wr_start_en),
      .wr_sec_addr  (wr_sec_addr),
      .wr_data      (wr_data),
      .rd_busy      (rd_busy),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_start_en  (rd_start_en),
      .rd_sec_addr  (rd_sec_addr),
      .test_done    (test_done),
      .error_flag   (error_flag),
      .err_cnt      (err_cnt),
      .fail_sec     (fail_sec)
   );

   // Model: word w of sector s is (s<<8 | w) cut to the data width.
   function automatic logic [DW-1:0] pat(input int s, input int w);
      return DW'((s << 8) | w);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sd);
      #1;
   endtask

   task automatic clear_plan();
      for (int s = 0; s < NSEC; s++) begin
         nread[s] = WPS;
         for (int w = 0; w < WPS; w++) corrupt[s][w] = 1'b0;
      end
   endtask

   // Sector-level outcome of a pass: mismatch count, first bad sector, sticky flag.
   task automatic expected_outcome(output int e_err, output logic [31:0] e_fail, output bit e_flag);
      bit found;
      bit bad;
      found  = 1'b0;
      e_err  = 0;
      e_fail = '0;
      for (int s = 0; s < NSEC; s++) begin
         bad = (nread[s] != WPS);
         for (int w = 0; w < nread[s]; w++) begin
            if (corrupt[s][w]) begin
               e_err++;
               bad = 1'b1;
            end
         end
         if (bad && !found) begin
            found  = 1'b1;
            e_fail = SA + 32'(s);
         end
      end
      if (e_err > 65535) e_err = 65535;
      e_flag = found;
   endtask

   task automatic wait_pulse(input bit rd, input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sd);
         if ((rd ? rd_start_en : wr_start_en) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s actual=no_pulse required=pulse_within_40_cycles", name);
      end
   endtask

   task automatic write_sector(input int s, input bit check, input bit restart_mid);
      tick();
      wr_busy = 1'b1;
      for (int w = 0; w < WPS; w++) begin
         tick();
         wr_req = 1'b1;
         if (restart_mid && w == 100) restart = 1'b1;
         tick();
         wr_req  = 1'b0;
         restart = 1'b0;
         if (check) chk($sformatf("wr_data s%0d w%0d", s, w), 32'(wr_data), 32'(pat(s, w)));
         mem[s][w] = wr_data;
         repeat ($urandom_range(0, 1)) tick();
      end
      tick();
      wr_busy = 1'b0;
   endtask

   task automatic read_sector(input int s);
      tick();
      rd_busy = 1'b1;
      for (int r = 0; r < nread[s]; r++) begin
         tick();
         rd_en   = 1'b1;
         rd_data = corrupt[s][r] ? (mem[s][r] ^ DW'($urandom_range(1, 65535))) : mem[s][r];
         tick();
         rd_en   = 1'b0;
         rd_data = DW'($urandom);
         repeat ($urandom_range(0, 1)) tick();
      end
      tick();
      rd_busy = 1'b0;
   endtask

   task automatic run_pass(input string tag, input bit restart_mid);
      bit          ok;
      int          e_err;
      logic [31:0] e_fail;
      bit          e_flag;
      for (int s = 0; s < NSEC; s++) begin
         wait_pulse(1'b0, {tag, " wr_start"}, ok);
         chk({tag, " wr_sec_addr"}, wr_sec_addr, SA + 32'(s));
         chk({tag, " test_done_busy"}, 32'(test_done), 32'd0);
         @(negedge clk_sd);
         chk({tag, " wr_start_width"}, 32'(wr_start_en), 32'd0);
         write_sector(s, 1'b1, restart_mid && s == 0);
         wait_pulse(1'b1, {tag, " rd_start"}, ok);
         chk({tag, " rd_sec_addr"}, rd_sec_addr, SA + 32'(s));
         @(negedge clk_sd);
         chk({tag, " rd_start_width"}, 32'(rd_start_en), 32'd0);
         read_sector(s);
      end
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk_sd);
         ok = (test_done === 1'b1);
      end
      expected_outcome(e_err, e_fail, e_flag);
      chk({tag, " test_done"}, 32'(test_done), 32'd1);
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'(e_err));
      chk({tag, " error_flag"}, 32'(error_flag), 32'(e_flag));
      chk({tag, " fail_sec"}, fail_sec, e_fail);
      repeat (4) tick();
      chk({tag, " done_hold"}, 32'(test_done), 32'd1);
      chk({tag, " no_start_in_done"}, 32'(wr_start_en), 32'd0);
   endtask

   task automatic pulse_restart(input string tag);
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk({tag, " clr_test_done"}, 32'(test_done), 32'd0);
      chk({tag, " clr_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, " clr_error_flag"}, 32'(error_flag), 32'd0);
      chk({tag, " clr_fail_sec"}, fail_sec, 32'd0);
      chk({tag, " restart_start"}, 32'(wr_start_en), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " wr_start_en"}, 32'(wr_start_en), 32'd0);
      chk({tag, " rd_start_en"}, 32'(rd_start_en), 32'd0);
      chk({tag, " wr_sec_addr"}, wr_sec_addr, 32'd0);
      chk({tag, " rd_sec_addr"}, rd_sec_addr, 32'd0);
      chk({tag, " wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, " test_done"}, 32'(test_done), 32'd0);
      chk({tag, " error_flag"}, 32'(error_flag), 32'd0);
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, " fail_sec"}, fail_sec, 32'd0);
   endtask

   initial begin
      bit ok;

      // Reset with init_done low, then stray controller strobes while IDLE.
      repeat (3) tick();
      check_reset_outputs("rst0");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         wr_req  = 1'b1;
         rd_en   = 1'b1;
         rd_data = DW'($urandom);
         tick();
         wr_req  = 1'b0;
         rd_en   = 1'b0;
      end
      tick();
      chk("idle wr_data", 32'(wr_data), 32'd0);
      chk("idle err_cnt", 32'(err_cnt), 32'd0);
      chk("idle error_flag", 32'(error_flag), 32'd0);
      chk("idle wr_start_en", 32'(wr_start_en), 32'd0);

      // Init edge starts a clean pass; word 0 proves the stray strobes did not advance data.
      clear_plan();
      sd_init_done = 1'b1;
      run_pass("clean1", 1'b0);

      // Restart from DONE; a restart during WR_WAIT must be ignored.
      pulse_restart("rs1");
      run_pass("clean2", 1'b0 | 1'b1);

      // Word 5 of sector 2001 corrupted on readback.
      pulse_restart("rs2");
      clear_plan();
      corrupt[1][5] = 1'b1;
      run_pass("corrupt", 1'b0);
      chk("corrupt lit_err_cnt", 32'(err_cnt), 32'd1);
      chk("corrupt lit_fail_sec", fail_sec, 32'd2001);

      // Sector 2000 returns only 255 words.
      pulse_restart("rs3");
      clear_plan();
      nread[0] = WPS - 1;
      run_pass("short", 1'b0);
      chk("short lit_fail_sec", fail_sec, 32'd2000);
      chk("short lit_err_cnt", 32'(err_cnt), 32'd0);
      chk("short lit_error_flag", 32'(error_flag), 32'd1);

      // Random corruption and random short final sector.
      pulse_restart("rs4");
      clear_plan();
      for (int k = 0; k < 5; k++) corrupt[$urandom_range(0, NSEC - 1)][$urandom_range(0, WPS - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) nread[1] = WPS - 1;
      run_pass("random", 1'b0);

      // Reset in RD_WAIT of sector 0 with a mismatch already counted.
      pulse_restart("rs5");
      clear_plan();
      wait_pulse(1'b0, "rst_mid wr_start", ok);
      chk("rst_mid lit_wr_sec_addr", wr_sec_addr, 32'd2000);
      write_sector(0, 1'b0, 1'b0);
      wait_pulse(1'b1, "rst_mid rd_start", ok);
      tick();
      rd_busy = 1'b1;
      for (int r = 0; r < 10; r++) begin
         tick();
         rd_en   = 1'b1;
         rd_data = (r == 3) ? ~mem[0][r] : mem[0][r];
         tick();
         rd_en   = 1'b0;
      end
      tick();
      chk("rst_mid pre_err_cnt", 32'(err_cnt), 32'd1);
      reset   = 1'b1;
      rd_busy = 1'b0;
      tick();
      check_reset_outputs("rst_mid");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_hold no_start", 32'(wr_start_en), 32'd0);
      end
      reset = 1'b0;
      run_pass("after_rst", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
